// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared ALU operation codes, RV32I opcodes and command type
// Purpose: constants shared by the issue stage, its decoder and the ALU.
// Ports: none (package).
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_OP1  = 4'd11,
        ALU_NAND = 4'd12
    } alu_func_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational RV32I to ALU command decoder
// Purpose: map one instruction plus operands to an ALU command.
// Ports: i instr/pc/rs1_data/rs2_data; o ALU_func/op1/op2/rd/illegal.
module alu_issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_func_e   ALU_func,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;
    logic        w_legal;
    alu_func_e   w_func;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_shamt  = {27'b0, instr[24:20]};

    always_comb begin
        w_legal = 1'b1;
        w_func  = ALU_ADD;
        w_op1   = '0;
        w_op2   = '0;
        case (w_opcode)
            OPC_OP: begin
                w_op1 = rs1_data;
                w_op2 = rs2_data;
                case (w_funct3)
                    3'b000:  w_func = w_funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  w_func = ALU_SLL;
                    3'b010:  w_func = ALU_SLT;
                    3'b011:  w_func = ALU_SLTU;
                    3'b100:  w_func = ALU_XOR;
                    3'b101:  w_func = w_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_func = ALU_OR;
                    default: w_func = ALU_AND;
                endcase
                // Alternate funct7 only exists for ADD/SUB and SRL/SRA
                if (!(w_funct7 == F7_BASE ||
                      (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
                    w_legal = 1'b0;
            end
            OPC_OP_IMM: begin
                w_op1 = rs1_data;
                w_op2 = w_imm_i;
                case (w_funct3)
                    3'b000:  w_func = ALU_ADD;
                    3'b001: begin
                        w_func = ALU_SLL;
                        w_op2  = w_shamt;
                        if (w_funct7 != F7_BASE) w_legal = 1'b0;
                    end
                    3'b010:  w_func = ALU_SLT;
                    3'b011:  w_func = ALU_SLTU;
                    3'b100:  w_func = ALU_XOR;
                    3'b101: begin
                        w_func = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        w_op2  = w_shamt;
                        if (w_funct7 != F7_BASE && w_funct7 != F7_ALT) w_legal = 1'b0;
                    end
                    3'b110:  w_func = ALU_OR;
                    default: w_func = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                w_func = ALU_LUI;
                w_op2  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_op1 = pc;
                w_op2 = w_imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                // Link address pc+4 is computed by the ALU
                w_op1 = pc;
                w_op2 = 32'd4;
            end
            default: w_legal = 1'b0;
        endcase
        // Every illegal form presents the same neutral command
        if (!w_legal) begin
            w_func = ALU_ADD;
            w_op1  = '0;
            w_op2  = '0;
        end
    end

    assign ALU_func = w_func;
    assign op1      = w_op1;
    assign op2      = w_op2;
    assign rd       = w_legal ? instr[11:7] : 5'd0;
    assign illegal  = !w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - one-entry registered ALU issue stage with valid/ready handshake
// Purpose: decode an instruction and hold the ALU command for the execute stage.
// Ports: clk, rst; in_valid/in_ready, instr, pc, rs1_data, rs2_data, flush;
//        out_valid/out_ready, op1, op2, ALU_func, rd, illegal.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  ALU_func,
    output logic [4:0]  rd,
    output logic        illegal
);

    alu_func_e   w_func;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [4:0]  w_rd;
    logic        w_illegal;
    logic        w_capture;

    logic        r_valid;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [3:0]  r_func;
    logic [4:0]  r_rd;
    logic        r_illegal;

    alu_issue_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .ALU_func (w_func),
        .op1      (w_op1),
        .op2      (w_op2),
        .rd       (w_rd),
        .illegal  (w_illegal)
    );

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_func    <= ALU_ADD;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            // Data left as-is; it is don't-care once out_valid drops
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_func    <= w_func;
            r_rd      <= w_rd;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign ALU_func  = r_func;
    assign rd        = r_rd;
    assign illegal   = r_illegal;

endmodule
